// File: rtl/exec_mc.sv
// exec_mc: multi-cycle execute stage with ALU, shift-add multiplier, jump/branch redirect and dmem address generation
module exec_mc #(
  parameter int DMEM_ADDR_WIDTH = 12,
  parameter int IALU_WORD_WIDTH = 16,
  parameter int PC_WIDTH = 12,
  parameter int PMEM_ADDR_WIDTH = 12,
  parameter int PMEM_WORD_WIDTH = 16,
  parameter int REG_IDX_WIDTH = 4,
  parameter int MUL_BITS_PER_CYCLE = 1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [2:0]                 in_alu_op,
  input  logic                       in_act_jump_to_ialu_res,
  input  logic                       in_act_branch_if_zero,
  input  logic                       in_act_load_dmem,
  input  logic                       in_act_store_dmem,
  input  logic                       in_act_write_res_to_reg,
  input  logic [PMEM_WORD_WIDTH-1:0] in_instr,
  input  logic [PC_WIDTH-1:0]        in_pc,
  input  logic [REG_IDX_WIDTH-1:0]   in_res_reg_idx,
  input  logic [IALU_WORD_WIDTH-1:0] in_src1,
  input  logic [IALU_WORD_WIDTH-1:0] in_src2,
  output logic                       out_stall,
  output logic                       out_valid,
  output logic                       out_act_load_dmem,
  output logic                       out_act_store_dmem,
  output logic                       out_act_write_res_to_reg,
  output logic [DMEM_ADDR_WIDTH-1:0] out_dmem_rd_addr,
  output logic [DMEM_ADDR_WIDTH-1:0] out_dmem_wr_addr,
  output logic [IALU_WORD_WIDTH-1:0] out_dmem_wr_word,
  output logic                       out_flush,
  output logic                       out_set_pc,
  output logic [PMEM_ADDR_WIDTH-1:0] out_new_pc,
  output logic [IALU_WORD_WIDTH-1:0] out_res,
  output logic [REG_IDX_WIDTH-1:0]   out_res_reg_idx,
  output logic [PMEM_WORD_WIDTH-1:0] out_instr
);
  localparam int W = IALU_WORD_WIDTH;
  localparam int B = MUL_BITS_PER_CYCLE;
  localparam int N = W / B;
  localparam int SW = $clog2(W);
  localparam int CW = $clog2(N + 1);
  typedef enum logic [1:0] {IDLE, MUL_BUSY, MUL_DONE} state_t;
  state_t st;
  logic v, jump, bz, ld, sd, wr, acc, taken;
  logic [PMEM_WORD_WIDTH-1:0] instr;
  logic [PC_WIDTH-1:0] pc;
  logic [REG_IDX_WIDTH-1:0] idx;
  logic [W-1:0] s1, s2, res, mcand, mplier, alu, pp, target;
  logic [CW-1:0] cnt;
  assign out_stall = st == MUL_BUSY;
  assign acc = in_valid & !out_stall & !out_flush;
  assign pp = mcand * W'(mplier[B-1:0]);
  assign target = W'(pc) + s2;
  assign taken = jump | (bz & s1 == '0);
  // single-cycle ALU result computed straight from decode's operands
  always_comb begin
    alu = in_alu_op == 3'd0 ? in_src2 :
          in_alu_op == 3'd1 ? in_src1 + in_src2 :
          in_alu_op == 3'd2 ? in_src1 - in_src2 :
          in_alu_op == 3'd3 ? in_src1 & in_src2 :
          in_alu_op == 3'd4 ? in_src1 | in_src2 :
          in_alu_op == 3'd5 ? in_src1 ^ in_src2 :
          in_alu_op == 3'd6 ? in_src1 << in_src2[SW-1:0] : '0;
  end
  assign out_valid = v;
  assign out_flush = v & taken;
  assign out_set_pc = out_flush;
  assign out_new_pc = out_flush ? (jump ? res[PMEM_ADDR_WIDTH-1:0] : target[PMEM_ADDR_WIDTH-1:0]) : '0;
  assign out_act_load_dmem = v & ld;
  assign out_act_store_dmem = v & sd;
  assign out_act_write_res_to_reg = v & wr;
  assign out_dmem_rd_addr = out_act_load_dmem ? s1[DMEM_ADDR_WIDTH-1:0] : '0;
  assign out_dmem_wr_addr = out_act_store_dmem ? s2[DMEM_ADDR_WIDTH-1:0] : '0;
  assign out_dmem_wr_word = out_act_store_dmem ? s1 : '0;
  assign out_res = v ? res : '0;
  assign out_res_reg_idx = v ? idx : '0;
  assign out_instr = v ? instr : '0;
  // FSM: sample on accept, iterate the shift-add multiplier while busy, drop valid otherwise
  always_ff @(posedge clock) begin
    if (reset) begin
      st <= IDLE;
      v <= 1'b0;
      {jump, bz, ld, sd, wr} <= '0;
      instr <= '0;
      pc <= '0;
      idx <= '0;
      s1 <= '0;
      s2 <= '0;
      res <= '0;
      mcand <= '0;
      mplier <= '0;
      cnt <= '0;
    end else if (acc) begin
      {jump, bz, ld, sd, wr} <= {in_act_jump_to_ialu_res, in_act_branch_if_zero, in_act_load_dmem, in_act_store_dmem, in_act_write_res_to_reg};
      instr <= in_instr;
      pc <= in_pc;
      idx <= in_res_reg_idx;
      s1 <= in_src1;
      s2 <= in_src2;
      mcand <= in_src1;
      mplier <= in_src2;
      v <= in_alu_op != 3'd7;
      st <= in_alu_op == 3'd7 ? MUL_BUSY : IDLE;
      res <= in_alu_op == 3'd7 ? '0 : alu;
      cnt <= in_alu_op == 3'd7 ? CW'(N) : '0;
    end else if (st == MUL_BUSY) begin
      res <= res + pp;
      mcand <= mcand << B;
      mplier <= mplier >> B;
      cnt <= cnt - CW'(1);
      v <= cnt == CW'(1);
      st <= cnt == CW'(1) ? MUL_DONE : MUL_BUSY;
    end else begin
      v <= 1'b0;
      st <= IDLE;
    end
  end
endmodule

// File: tb/tb_exec_mc.sv
// tb_exec_mc: directed and randomized checks of exec_mc against an arithmetic reference model
module tb_exec_mc;
  logic clock, reset, in_valid;
  logic [2:0] in_alu_op;
  logic in_act_jump_to_ialu_res, in_act_branch_if_zero, in_act_load_dmem, in_act_store_dmem, in_act_write_res_to_reg;
  logic [15:0] in_instr;
  logic [11:0] in_pc;
  logic [3:0] in_res_reg_idx;
  logic [15:0] in_src1, in_src2;
  logic out_stall, out_valid, out_act_load_dmem, out_act_store_dmem, out_act_write_res_to_reg;
  logic [11:0] out_dmem_rd_addr, out_dmem_wr_addr;
  logic [15:0] out_dmem_wr_word;
  logic out_flush, out_set_pc;
  logic [11:0] out_new_pc;
  logic [15:0] out_res;
  logic [3:0] out_res_reg_idx;
  logic [15:0] out_instr;
  int n_chk = 0, n_fail = 0;
  int unsigned e_op, e_fl, e_pc, e_a, e_b, e_instr, e_idx;

  exec_mc dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_alu_op(in_alu_op),
    .in_act_jump_to_ialu_res(in_act_jump_to_ialu_res), .in_act_branch_if_zero(in_act_branch_if_zero),
    .in_act_load_dmem(in_act_load_dmem), .in_act_store_dmem(in_act_store_dmem),
    .in_act_write_res_to_reg(in_act_write_res_to_reg), .in_instr(in_instr), .in_pc(in_pc),
    .in_res_reg_idx(in_res_reg_idx), .in_src1(in_src1), .in_src2(in_src2),
    .out_stall(out_stall), .out_valid(out_valid), .out_act_load_dmem(out_act_load_dmem),
    .out_act_store_dmem(out_act_store_dmem), .out_act_write_res_to_reg(out_act_write_res_to_reg),
    .out_dmem_rd_addr(out_dmem_rd_addr), .out_dmem_wr_addr(out_dmem_wr_addr),
    .out_dmem_wr_word(out_dmem_wr_word), .out_flush(out_flush), .out_set_pc(out_set_pc),
    .out_new_pc(out_new_pc), .out_res(out_res), .out_res_reg_idx(out_res_reg_idx), .out_instr(out_instr)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned model(input int unsigned op, input int unsigned a, input int unsigned b);
    case (op)
      0: return b;
      1: return (a + b) & 32'hFFFF;
      2: return (a - b) & 32'hFFFF;
      3: return a & b;
      4: return a | b;
      5: return a ^ b;
      6: return (a << (b % 16)) & 32'hFFFF;
      default: return (a * b) & 32'hFFFF;
    endcase
  endfunction

  function automatic logic [31:0] any_out();
    return {|out_valid, |out_stall, |out_act_load_dmem, |out_act_store_dmem, |out_act_write_res_to_reg,
            |out_dmem_rd_addr, |out_dmem_wr_addr, |out_dmem_wr_word, |out_flush, |out_set_pc,
            |out_new_pc, |out_res, |out_res_reg_idx, |out_instr};
  endfunction

  function automatic logic [31:0] dmem_out();
    return {|out_act_load_dmem, |out_act_store_dmem, |out_dmem_rd_addr, |out_dmem_wr_addr,
            |out_dmem_wr_word, |out_flush, |out_set_pc, |out_new_pc};
  endfunction

  // fl: 0 plain, 1 jump, 2 branch-if-zero, 3 load, 4 store
  task automatic drive(input int unsigned op, input int unsigned fl, input int unsigned pc, input int unsigned a, input int unsigned b);
    e_op = op; e_fl = fl; e_pc = pc; e_a = a; e_b = b;
    e_instr = $urandom_range(0, 16'hFFFF);
    e_idx = $urandom_range(0, 15);
    in_alu_op = 3'(op);
    in_act_jump_to_ialu_res = fl == 1;
    in_act_branch_if_zero = fl == 2;
    in_act_load_dmem = fl == 3;
    in_act_store_dmem = fl == 4;
    in_act_write_res_to_reg = fl == 0 || fl == 3;
    in_pc = 12'(pc);
    in_src1 = 16'(a);
    in_src2 = 16'(b);
    in_instr = 16'(e_instr);
    in_res_reg_idx = 4'(e_idx);
    in_valid = 1'b1;
  endtask

  task automatic check_done();
    int unsigned r;
    logic tk;
    r = model(e_op, e_a, e_b);
    tk = e_fl == 1 || (e_fl == 2 && e_a == 0);
    chk("valid", out_valid, 1);
    chk("stall", out_stall, 0);
    chk("res", out_res, r);
    chk("flush", out_flush, tk);
    chk("set_pc", out_set_pc, tk);
    if (tk) chk("new_pc", out_new_pc, e_fl == 1 ? r & 32'hFFF : (e_pc + e_b) & 32'hFFF);
    chk("load", out_act_load_dmem, e_fl == 3);
    chk("store", out_act_store_dmem, e_fl == 4);
    chk("wr_reg", out_act_write_res_to_reg, e_fl == 0 || e_fl == 3);
    if (e_fl == 3) chk("rd_addr", out_dmem_rd_addr, e_a & 32'hFFF);
    if (e_fl == 4) begin
      chk("wr_addr", out_dmem_wr_addr, e_b & 32'hFFF);
      chk("wr_word", out_dmem_wr_word, e_a);
    end
    chk("instr", out_instr, e_instr);
    chk("reg_idx", out_res_reg_idx, e_idx);
  endtask

  task automatic wait_mul();
    int stalls;
    logic [31:0] leak;
    stalls = 0;
    leak = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (!out_stall) break;
      stalls++;
      leak |= dmem_out() | 32'(out_valid);
    end
    chk("mul_stall_cycles", stalls, 16);
    chk("busy_outputs_zero", leak, 0);
  endtask

  // one instruction in isolation; starts just after a rising edge with the stage free
  task automatic run_one(input int unsigned op, input int unsigned fl, input int unsigned pc, input int unsigned a, input int unsigned b);
    drive(op, fl, pc, a, b);
    @(posedge clock); #1;
    in_valid = 1'b0;
    if (op == 7) wait_mul();
    else @(negedge clock);
    check_done();
    @(negedge clock);
    chk("valid_after", out_valid, 0);
    @(posedge clock); #1;
  endtask

  initial begin
    int seen;
    reset = 1'b1;
    drive(0, 0, 0, 0, 0);
    in_valid = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("reset_outputs", any_out(), 0);
    @(posedge clock); #1;
    reset = 1'b0;
    run_one(1, 0, 12'h001, 16'hFFFF, 16'h0002);
    // multiply with a follow-on ADD held by decode through the stall
    drive(7, 0, 12'h002, 16'h0123, 16'h0010);
    @(posedge clock); #1;
    drive(1, 0, 12'h003, 16'h1111, 16'h2222);
    e_op = 7; e_a = 16'h0123; e_b = 16'h0010;
    wait_mul();
    chk("mul_res", out_res, 16'h1230);
    chk("mul_valid", out_valid, 1);
    @(posedge clock); #1;
    in_valid = 1'b0;
    @(negedge clock);
    chk("held_add_valid", out_valid, 1);
    chk("held_add_res", out_res, 16'h3333);
    @(negedge clock);
    chk("held_add_after", out_valid, 0);
    @(posedge clock); #1;
    // reset during the 5th busy cycle aborts the multiply
    drive(7, 0, 12'h004, 16'h00FF, 16'h00FF);
    @(posedge clock); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    chk("abort_outputs", any_out(), 0);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      seen |= 32'(out_valid);
    end
    chk("abort_no_product", seen, 0);
    @(posedge clock); #1;
    // taken branch, with the next instruction presented during the flush cycle
    drive(1, 2, 12'h010, 16'h0000, 16'h0020);
    @(posedge clock); #1;
    drive(1, 0, 12'h011, 16'h0001, 16'h0002);
    @(negedge clock);
    chk("br_valid", out_valid, 1);
    chk("br_flush", out_flush, 1);
    chk("br_set_pc", out_set_pc, 1);
    chk("br_new_pc", out_new_pc, 12'h030);
    @(negedge clock);
    chk("br_bubble", out_valid, 0);
    @(posedge clock); #1;
    in_valid = 1'b0;
    @(negedge clock);
    check_done();
    @(posedge clock); #1;
    run_one(1, 2, 12'h010, 16'h0001, 16'h0020);
    run_one(6, 0, 12'h020, 16'h0001, 16'h0013);
    run_one(2, 0, 12'h021, 16'h0000, 16'h0001);
    run_one(0, 4, 12'h022, 16'hBEEF, 16'h0ABC);
    run_one(7, 0, 12'h023, 16'hFFFF, 16'hFFFF);
    run_one(0, 1, 12'h024, 16'h0000, 16'h0FFF);
    run_one(1, 2, 12'hFF0, 16'h0000, 16'h0020);
    for (int i = 0; i < 40; i++)
      run_one($urandom_range(0, 7), $urandom_range(0, 4), $urandom_range(0, 12'hFFF),
              $urandom_range(0, 3) == 0 ? 0 : $urandom_range(0, 16'hFFFF), $urandom_range(0, 16'hFFFF));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
